// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two producers, the arbiter and the consumer.
// The arbiter uses the slave view; the driving environment uses master.
interface mux2_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_ready;

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Two-input valid/ready arbiter feeding a 2:1 mux select; registers the winning word.
// Define MUX2_ARB_FIXED_PRIO_EN for fixed priority (in0 wins); default is round-robin.
module mux2_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux2_rr_arbiter_if.slave  bus
);

    logic [1:0]            req;
    logic [1:0][WIDTH-1:0] din;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_sel_q,   out_sel_d;
    logic             last_q,      last_d;

    logic load;
    logic gnt_vld;
    logic gnt_idx;

    assign req  = {bus.in1_valid, bus.in0_valid};
    assign din  = {bus.in1_data,  bus.in0_data};
    assign load = !out_valid_q || bus.out_ready;

    always_comb begin
        gnt_vld = |req;
        gnt_idx = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
`ifdef MUX2_ARB_FIXED_PRIO_EN
            2'b11:   gnt_idx = 1'b0;
`else
            2'b11:   gnt_idx = !last_q;
`endif
            default: gnt_idx = 1'b0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        last_d      = last_q;
        if (load && gnt_vld) begin
            out_valid_d = 1'b1;
            out_data_d  = din[gnt_idx];
            out_sel_d   = gnt_idx;
            last_d      = gnt_idx;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // rst_n gates the readies so nothing is accepted while reset is held.
    assign bus.in0_ready = rst_n && load && gnt_vld && !gnt_idx;
    assign bus.in1_ready = rst_n && load && gnt_vld &&  gnt_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            last_q      <= last_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed test-plan sequences plus random traffic
// against a queue-based reference model of the one-slot output buffer.
module tb_mux2_rr_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mux2_rr_arbiter_if #(.WIDTH(8)) bus ();

    mux2_rr_arbiter #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MUX2_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    // Reference model: words held in the output slot, plus last shown word/sel.
    logic [8:0] q[$];
    logic [7:0] hold_data;
    logic       hold_sel;
    int         m_last;

    // Random-phase producer state.
    logic       p_v [2];
    logic [7:0] p_d [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        hold_data = 8'h00;
        hold_sel  = 1'b0;
        m_last    = 1;
    endtask

    // One cycle: apply inputs, check combinational readies and registered outputs
    // mid-cycle, then advance the model across the rising edge.
    task automatic cyc(input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1,
                       input logic ordy, output logic acc0, output logic acc1);
        int  win;
        bit  free;
        bus.in0_valid = v0;
        bus.in0_data  = d0;
        bus.in1_valid = v1;
        bus.in1_data  = d1;
        bus.out_ready = ordy;
        @(negedge clk);
        if (v0 && v1)  win = FIXED ? 0 : 1 - m_last;
        else if (v0)   win = 0;
        else if (v1)   win = 1;
        else           win = -1;
        free = (q.size() == 0) || ordy;
        acc0 = free && (win == 0);
        acc1 = free && (win == 1);
        chk("in0_ready", bus.in0_ready, acc0);
        chk("in1_ready", bus.in1_ready, acc1);
        chk("out_valid", bus.out_valid, q.size() != 0);
        chk("out_data",  bus.out_data,  hold_data);
        chk("out_sel",   bus.out_sel,   hold_sel);
        @(posedge clk);
        if (ordy && q.size() != 0) void'(q.pop_front());
        if (acc0 || acc1) begin
            q.push_back({acc1, acc1 ? d1 : d0});
            hold_sel  = acc1;
            hold_data = acc1 ? d1 : d0;
            m_last    = acc1 ? 1 : 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in0_valid = 1'b1;
        bus.in1_valid = 1'b1;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data",  bus.out_data,  8'h00);
        chk("rst_in0_ready", bus.in0_ready, 1'b0);
        chk("rst_in1_ready", bus.in1_ready, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic       a0, a1;
        int         i0, i1;
        logic [7:0] exp_seq [4];
        logic [7:0] held;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in0_valid = 1'b0;
        bus.in0_data  = 8'h00;
        bus.in1_valid = 1'b0;
        bus.in1_data  = 8'h00;
        bus.out_ready = 1'b0;
        model_reset();
        #12;
        do_reset();

        // Single in0 word.
        cyc(1'b1, 8'h11, 1'b0, 8'h00, 1'b1, a0, a1);
        chk("t1_accept", a0, 1'b1);
        chk("t1_valid", bus.out_valid, 1'b1);
        chk("t1_data",  bus.out_data,  8'h11);
        chk("t1_sel",   bus.out_sel,   1'b0);

        // Contended stream from the reset pointer.
        do_reset();
        if (FIXED) exp_seq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        else       exp_seq = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 8'hA0 + 8'(i0), 1'b1, 8'hB0 + 8'(i1), 1'b1, a0, a1);
            if (a0) i0++;
            if (a1) i1++;
            chk("rr_seq_data", bus.out_data, exp_seq[k]);
            chk("rr_seq_sel",  bus.out_sel,  (exp_seq[k] >= 8'hB0));
        end

        // Backpressure: readies low, output frozen, then resume.
        held = bus.out_data;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 8'hA0 + 8'(i0), 1'b1, 8'hB0 + 8'(i1), 1'b0, a0, a1);
            if (a0) i0++;
            if (a1) i1++;
            chk("stall_hold", bus.out_data, held);
        end
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 8'hA0 + 8'(i0), 1'b1, 8'hB0 + 8'(i1), 1'b1, a0, a1);
            if (a0) i0++;
            if (a1) i1++;
        end

        // Asynchronous reset while the output register is full.
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_valid", bus.out_valid, 1'b0);
        chk("async_data",  bus.out_data,  8'h00);
        chk("async_sel",   bus.out_sel,   1'b0);
        do_reset();
        cyc(1'b1, 8'hC0, 1'b1, 8'hD0, 1'b1, a0, a1);
        chk("post_rst_sel",  bus.out_sel,  1'b0);
        chk("post_rst_data", bus.out_data, 8'hC0);

        // Lone in1 requester after an in1 grant.
        cyc(1'b0, 8'h00, 1'b1, 8'h33, 1'b1, a0, a1);
        cyc(1'b0, 8'h00, 1'b1, 8'h5C, 1'b1, a0, a1);
        chk("lone_in1_sel",  bus.out_sel,  1'b1);
        chk("lone_in1_data", bus.out_data, 8'h5C);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, a0, a1);
        chk("idle_drain", bus.out_valid, 1'b0);

        // Random traffic; producers hold valid/data until accepted.
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        p_d[0] = 8'h00; p_d[1] = 8'h00;
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_v[p] && ($urandom_range(0, 3) != 0)) begin
                    p_v[p] = 1'b1;
                    p_d[p] = 8'($urandom);
                end
            end
            cyc(p_v[0], p_d[0], p_v[1], p_d[1], 1'($urandom_range(0, 2) != 0), a0, a1);
            if (a0) p_v[0] = 1'b0;
            if (a1) p_v[1] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
